// File: rtl/lpm_walker.sv
`default_nettype none
// ============================================================================
//  Module      : lpm_walker
//  Description : Trie-walk engine that sits in front of LpmMemory. It takes one
//                tagged longest-prefix-match lookup at a time, issues one
//                memory read per trie level, and follows child pointers until
//                it reaches a leaf or the last level. It then emits a tagged
//                {hit, result} record downstream.
//  Revision    : 1.0  initial release
// ============================================================================
module lpm_walker #(
  parameter int          TAG_W     = 16,
  parameter int          KEY_W     = 32,
  parameter int          STRIDE    = 8,
  parameter int          RES_W     = 16,
  parameter logic [31:0] ROOT_BASE = 32'h0000_0000
) (
  input  logic                     CLK,
  input  logic                     nRST,
  // lookup request side
  input  logic                     in_enq__ENA,
  input  logic [TAG_W+KEY_W-1:0]   in_enq__v,
  output logic                     in_enq__RDY,
  // memory read request / response
  output logic                     mem_req__ENA,
  output logic [31:0]              mem_req__v,
  input  logic                     mem_req__RDY,
  output logic                     mem_resAccept__ENA,
  input  logic                     mem_resAccept__RDY,
  input  logic [31:0]              mem_resValue,
  // result side
  output logic                     out_enq__ENA,
  output logic [TAG_W+RES_W:0]     out_enq__v,
  input  logic                     out_enq__RDY
);

  localparam int                LEVELS     = KEY_W / STRIDE;
  localparam int                LVL_W      = $clog2(LEVELS) + 1;
  localparam logic [LVL_W-1:0]  LAST_LEVEL = LVL_W'(LEVELS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    EMIT  = 2'd3
  } state_t;

  state_t               state;
  state_t               state_nxt;

  logic [TAG_W-1:0]     tag;
  logic [KEY_W-1:0]     key;
  logic [31:0]          base;
  logic [LVL_W-1:0]     level;
  logic                 hit;
  logic [RES_W-1:0]     result;

  logic [31:0]          shift_amt;
  logic [KEY_W-1:0]     key_aligned;
  logic [STRIDE-1:0]    chunk;
  logic                 accept;
  logic                 res_fire;
  logic                 is_leaf;
  logic                 at_last;

  // The chunk for the current level is brought to the top of the key by a
  // shift, which avoids a variable-base part-select on the raw key.
  assign shift_amt   = 32'(level) * 32'(STRIDE);
  assign key_aligned = key << shift_amt;
  assign chunk       = key_aligned[KEY_W-1 -: STRIDE];

  // Child-slot address; the add wraps modulo 2^32 by construction.
  assign mem_req__v  = base + 32'(chunk);

  assign out_enq__v  = {tag, hit, result};

  assign accept      = (state == IDLE) && in_enq__ENA;
  assign res_fire    = (state == WAIT) && mem_resAccept__RDY;
  assign is_leaf     = mem_resValue[31];
  assign at_last     = (level == LAST_LEVEL);

  // State register.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and handshake outputs. ISSUE and WAIT are separate states, so
  // a read request and a response accept never coincide.
  always_comb begin
    state_nxt          = state;
    in_enq__RDY        = 1'b0;
    mem_req__ENA       = 1'b0;
    mem_resAccept__ENA = 1'b0;
    out_enq__ENA       = 1'b0;
    case (state)
      IDLE: begin
        in_enq__RDY = 1'b1;
        if (in_enq__ENA) begin
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        mem_req__ENA = mem_req__RDY;
        if (mem_req__RDY) begin
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        mem_resAccept__ENA = mem_resAccept__RDY;
        if (mem_resAccept__RDY) begin
          state_nxt = (is_leaf || at_last) ? EMIT : ISSUE;
        end
      end
      EMIT: begin
        out_enq__ENA = out_enq__RDY;
        if (out_enq__RDY) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Lookup context: latch on accept, then descend or finish on each response.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      tag    <= '0;
      key    <= '0;
      base   <= '0;
      level  <= '0;
      hit    <= 1'b0;
      result <= '0;
    end else if (accept) begin
      tag   <= in_enq__v[TAG_W+KEY_W-1:KEY_W];
      key   <= in_enq__v[KEY_W-1:0];
      base  <= ROOT_BASE;
      level <= '0;
    end else if (res_fire) begin
      if (is_leaf) begin
        hit    <= 1'b1;
        result <= mem_resValue[RES_W-1:0];
      end else if (at_last) begin
        hit    <= 1'b0;
        result <= '0;
      end else begin
        base  <= {1'b0, mem_resValue[30:0]};
        level <= level + LVL_W'(1);
      end
    end
  end

  // A lookup offered while a walk is in progress is dropped; flag it.
  in_enq_only_when_idle: assert property (
    @(posedge CLK) disable iff (!nRST) in_enq__ENA |-> (state == IDLE)
  );

endmodule
`default_nettype wire

// File: tb/tb_lpm_walker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lpm_walker
//  Description : Self-checking bench for lpm_walker with a behavioural memory,
//                an address/result scoreboard and a vector table.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_lpm_walker;

  localparam int OUT_W = 33;

  logic CLK = 1'b0;
  logic nRST = 1'b0;
  always #5 CLK = ~CLK;

  int unsigned cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // main instance
  logic             in_ena = 1'b0;
  logic [47:0]      in_v = '0;
  logic             in_rdy;
  logic             req_ena;
  logic [31:0]      req_v;
  logic             req_rdy = 1'b1;
  logic             acc_ena;
  logic             rsp_rdy = 1'b0;
  logic [31:0]      rsp_val = '0;
  logic             out_ena;
  logic [OUT_W-1:0] out_v;
  logic             out_rdy = 1'b1;

  lpm_walker #(.TAG_W(16), .KEY_W(32), .STRIDE(8), .RES_W(16), .ROOT_BASE(32'h0)) dut (
    .CLK(CLK), .nRST(nRST),
    .in_enq__ENA(in_ena), .in_enq__v(in_v), .in_enq__RDY(in_rdy),
    .mem_req__ENA(req_ena), .mem_req__v(req_v), .mem_req__RDY(req_rdy),
    .mem_resAccept__ENA(acc_ena), .mem_resAccept__RDY(rsp_rdy), .mem_resValue(rsp_val),
    .out_enq__ENA(out_ena), .out_enq__v(out_v), .out_enq__RDY(out_rdy)
  );

  // wrap-around instance (root near the top of the address space)
  logic             wr_in_ena = 1'b0;
  logic [47:0]      wr_in_v = '0;
  logic             wr_in_rdy;
  logic             wr_req_ena;
  logic [31:0]      wr_req_v;
  logic             wr_req_rdy = 1'b1;
  logic             wr_acc_ena;
  logic             wr_rsp_rdy = 1'b0;
  logic [31:0]      wr_rsp_val = '0;
  logic             wr_out_ena;
  logic [OUT_W-1:0] wr_out_v;
  logic             wr_out_rdy = 1'b1;

  lpm_walker #(.TAG_W(16), .KEY_W(32), .STRIDE(8), .RES_W(16), .ROOT_BASE(32'hFFFF_FFF0)) dut_wrap (
    .CLK(CLK), .nRST(nRST),
    .in_enq__ENA(wr_in_ena), .in_enq__v(wr_in_v), .in_enq__RDY(wr_in_rdy),
    .mem_req__ENA(wr_req_ena), .mem_req__v(wr_req_v), .mem_req__RDY(wr_req_rdy),
    .mem_resAccept__ENA(wr_acc_ena), .mem_resAccept__RDY(wr_rsp_rdy), .mem_resValue(wr_rsp_val),
    .out_enq__ENA(wr_out_ena), .out_enq__v(wr_out_v), .out_enq__RDY(wr_out_rdy)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // memory image and model state
  logic [31:0] mem [logic [31:0]];
  logic [31:0]      exp_addr_q[$];
  logic [OUT_W-1:0] exp_out_q[$];
  int          mem_delay = 2;
  int          mem_cnt = 0;
  logic        mem_busy = 1'b0;
  logic [31:0] rd_word = '0;
  int          req_stall = 0;
  logic        out_block = 1'b0;
  int          req_seen = 0;
  int          done_cnt = 0;
  int unsigned accept_cyc = 0;
  int unsigned out_cyc = 0;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 32'h0;
  endfunction

  // memory model + scoreboard: drive ready lines just after each falling edge,
  // then sample what will fire on the next rising edge
  initial begin
    forever begin
      @(negedge CLK);
      #1;
      if (mem_busy && mem_cnt > 0) mem_cnt--;
      rsp_rdy = mem_busy && (mem_cnt == 0);
      rsp_val = rsp_rdy ? rd_word : 32'h0;
      req_rdy = (req_stall == 0);
      if (req_stall > 0) req_stall--;
      out_rdy = !out_block;
      #1;
      if (nRST) begin
        if (in_ena && in_rdy) accept_cyc = cyc + 1;
        if (req_ena && acc_ena) check("req_acc_overlap", 1, 0);
        if (req_ena && !req_rdy) check("req_without_rdy", 1, 0);
        if (req_ena) begin
          if (exp_addr_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL req_extra: got addr %0h expected no request", req_v);
          end else begin
            check("req_addr", req_v, exp_addr_q.pop_front());
          end
          check("req_while_busy", mem_busy, 0);
          mem_busy = 1'b1;
          mem_cnt  = mem_delay + 1;
          rd_word  = mem_rd(req_v);
          req_seen++;
        end
        if (acc_ena) mem_busy = 1'b0;
        if (out_ena) begin
          out_cyc = cyc + 1;
          if (exp_out_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL out_extra: got %0h expected no output", out_v);
          end else begin
            check("out_v", out_v, exp_out_q.pop_front());
          end
          done_cnt++;
        end
      end
    end
  end

  // push expected addresses (reference walk) and result, then offer the lookup
  task automatic start_lookup(input logic [15:0] tag, input logic [31:0] key,
                              input logic hit, input logic [15:0] res);
    logic [31:0] b;
    logic [31:0] a;
    logic [31:0] w;
    b = 32'h0;
    for (int l = 0; l < 4; l++) begin
      a = b + {24'h0, key[31-8*l -: 8]};
      exp_addr_q.push_back(a);
      w = mem_rd(a);
      if (w[31] || l == 3) break;
      b = {1'b0, w[30:0]};
    end
    exp_out_q.push_back({tag, hit, res});
    req_seen = 0;
    for (int i = 0; i < 50 && !in_rdy; i++) @(negedge CLK);
    in_ena = 1'b1;
    in_v   = {tag, key};
    @(negedge CLK);
    in_ena = 1'b0;
  endtask

  task automatic wait_done(input int d0);
    for (int i = 0; i < 1000 && done_cnt == d0; i++) @(negedge CLK);
    check("lookup_completes", (done_cnt != d0), 1);
  endtask

  typedef struct {
    logic [15:0] tag;
    logic [31:0] key;
    int          nreq;
    logic        hit;
    logic [15:0] res;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int d0;
    logic [OUT_W-1:0] t5_exp;

    mem[32'h0000_000A] = 32'h0000_0100;
    mem[32'h0000_0100] = 32'h0000_0200;
    mem[32'h0000_0200] = 32'h0000_0300;
    mem[32'h0000_0301] = 32'h8000_0007;
    mem[32'h0000_0302] = 32'h0000_0400;
    mem[32'h0000_000B] = 32'h8000_0055;
    mem[32'h0000_0101] = 32'hFFFF_ABCD;
    mem[32'h0000_0102] = 32'h7FFF_FF00;
    mem[32'h7FFF_FF03] = 32'h8000_1234;
    mem[32'h0000_00FF] = 32'h8000_FFFF;
    mem[32'h0000_000D] = 32'h8000_0000;

    vecs[0] = '{16'h1001, 32'h0B00_0001, 1, 1'b1, 16'h0055};  // root leaf
    vecs[1] = '{16'h1002, 32'h0A00_0001, 4, 1'b1, 16'h0007};  // 4-level hit
    vecs[2] = '{16'h1003, 32'h0A00_0002, 4, 1'b0, 16'h0000};  // miss at depth
    vecs[3] = '{16'h1004, 32'h0A01_0000, 2, 1'b1, 16'hABCD};  // leaf, junk upper bits
    vecs[4] = '{16'h1005, 32'h0A02_0300, 3, 1'b1, 16'h1234};  // 3-level, high pointer
    vecs[5] = '{16'h1006, 32'hFF00_0000, 1, 1'b1, 16'hFFFF};  // max chunk, max result
    vecs[6] = '{16'h1007, 32'h0D00_0000, 1, 1'b1, 16'h0000};  // hit with zero result
    vecs[7] = '{16'hBEEF, 32'h0000_0000, 4, 1'b0, 16'h0000};  // all-zero chain

    // reset state
    #3;
    check("rst_in_rdy", in_rdy, 1);
    check("rst_req_ena", req_ena, 0);
    check("rst_acc_ena", acc_ena, 0);
    check("rst_out_ena", out_ena, 0);
    check("rst_out_v", out_v, 0);
    check("rst_req_v", req_v, 0);
    @(negedge CLK);
    @(negedge CLK);
    nRST = 1'b1;
    @(negedge CLK);

    // table: each vector with its own memory delay, latency checked
    for (int i = 0; i < 8; i++) begin
      mem_delay = i % 3;
      d0 = done_cnt;
      start_lookup(vecs[i].tag, vecs[i].key, vecs[i].hit, vecs[i].res);
      wait_done(d0);
      check("req_count", req_seen, vecs[i].nreq);
      check("latency", out_cyc - accept_cyc, 1 + vecs[i].nreq * (mem_delay + 2));
    end

    // backpressure on both memory request and output
    mem_delay = 1;
    out_block = 1'b1;
    req_stall = 6;
    d0 = done_cnt;
    t5_exp = {16'h3001, 1'b1, 16'h0055};
    start_lookup(16'h3001, 32'h0B00_0001, 1'b1, 16'h0055);
    for (int i = 0; i < 200 && (exp_addr_q.size() != 0 || mem_busy); i++) @(negedge CLK);
    check("bp_reach_emit", (exp_addr_q.size() == 0 && !mem_busy), 1);
    @(negedge CLK);
    for (int i = 0; i < 7; i++) begin
      check("bp_out_v_stable", out_v, t5_exp);
      check("bp_in_rdy_low", in_rdy, 0);
      check("bp_out_ena_low", out_ena, 0);
      @(negedge CLK);
    end
    out_block = 1'b0;
    wait_done(d0);
    check("bp_req_count", req_seen, 1);
    check("bp_in_rdy_after", in_rdy, 1);

    // asynchronous reset in the middle of a memory wait
    mem_delay = 8;
    start_lookup(16'h2001, 32'h0A00_0001, 1'b1, 16'h0007);
    repeat (3) @(negedge CLK);
    check("pre_rst_in_rdy", in_rdy, 0);
    #3;
    nRST = 1'b0;
    #1;
    check("mid_rst_in_rdy", in_rdy, 1);
    check("mid_rst_req_ena", req_ena, 0);
    check("mid_rst_acc_ena", acc_ena, 0);
    check("mid_rst_out_ena", out_ena, 0);
    check("mid_rst_out_v", out_v, 0);
    exp_addr_q.delete();
    exp_out_q.delete();
    mem_busy = 1'b0;
    mem_cnt  = 0;
    @(negedge CLK);
    nRST = 1'b1;
    @(negedge CLK);
    mem_delay = 0;
    d0 = done_cnt;
    start_lookup(vecs[1].tag, vecs[1].key, vecs[1].hit, vecs[1].res);
    wait_done(d0);
    check("post_rst_req_count", req_seen, 4);

    // root base near 2^32: address wraps
    wr_in_ena = 1'b1;
    wr_in_v   = {16'h0077, 32'h2000_0001};
    @(negedge CLK);
    wr_in_ena = 1'b0;
    begin
      int i;
      for (i = 0; i < 20; i++) begin
        #2;
        if (wr_req_ena) break;
        @(negedge CLK);
      end
      check("wrap_req_seen", wr_req_ena, 1);
      check("wrap_req_addr", wr_req_v, 32'h0000_0010);
      @(negedge CLK);
      wr_rsp_rdy = 1'b1;
      wr_rsp_val = 32'h8000_0042;
      for (i = 0; i < 20; i++) begin
        #2;
        if (wr_acc_ena) break;
        @(negedge CLK);
      end
      check("wrap_acc_seen", wr_acc_ena, 1);
      @(negedge CLK);
      wr_rsp_rdy = 1'b0;
      wr_rsp_val = 32'h0;
      for (i = 0; i < 20; i++) begin
        #2;
        if (wr_out_ena) break;
        @(negedge CLK);
      end
      check("wrap_out_seen", wr_out_ena, 1);
      check("wrap_out_v", wr_out_v, {16'h0077, 1'b1, 16'h0042});
    end

    @(negedge CLK);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, %0d errors so far", errors);
    $fatal(1);
  end

endmodule
`default_nettype wire
